a0_trace_fifo: RTL and testbench

//  Downstream observer of the single-cycle CPU's a0 output. It samples a0 every clock and detects value changes.

---
 rtl/a0_trace_fifo_pkg.sv | 28 ++
 rtl/a0_trace_fifo_sync_fifo.sv | 69 ++++++
 rtl/a0_trace_fifo.sv | 112 +++++++++++
 tb/tb_a0_trace_fifo.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/a0_trace_fifo_pkg.sv
// ----------------------------------------------------------------------------
// a0trace_pkg
//   Shared types and defaults for the a0 trace FIFO slice.
//   - DATA_WIDTH_DEF / DEPTH_DEF / CYC_W_DEF : default build configuration
//   - ptr_w()     : pointer width for a power-of-two depth
//   - PTR_W       : pointer width of the default depth
//   - a0_entry_t  : one trace record {cycle stamp, a0 value} at default widths
// ----------------------------------------------------------------------------
package a0trace_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 8;
    localparam int CYC_W_DEF      = 16;

    // Depth is a power of two >= 2, so the pointer is exactly log2(depth) bits
    // and wraps on its own at the end of storage.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    localparam int PTR_W = ptr_w(DEPTH_DEF);

    typedef struct packed {
        logic [CYC_W_DEF-1:0]      cycle;
        logic [DATA_WIDTH_DEF-1:0] data;
    } a0_entry_t;

endpackage

// File: rtl/a0_trace_fifo_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//   Generic single-clock FIFO holding the trace entries.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//     push, wdata : write request / data; accepted when not full, or when a
//                   pop happens in the same cycle
//     pop         : read request; ignored when empty
//     rdata       : head entry, combinational from storage, 0 when empty
//     full, empty : occupancy flags
//     count       : entries held (0..DEPTH)
// ----------------------------------------------------------------------------
module sync_fifo
    import a0trace_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               pop,
    output logic [WIDTH-1:0]   rdata,
    output logic               full,
    output logic               empty,
    output logic [ptr_w(DEPTH):0] count
);

    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO may still take a write when the head leaves in the same cycle.
    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);

    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/a0_trace_fifo.sv
// ----------------------------------------------------------------------------
// a0_trace_fifo
//   Watches the CPU a0 register every clock; each change of value is queued
//   as {cycle stamp, new value} and drained over a valid/ready stream. The CPU
//   is never stalled: a change arriving while the queue is full is dropped and
//   recorded in the sticky overflow flag.
//
//   Optional feature macro: A0_TRACE_TIMESTAMP_EN
//     defined     : free-running CYC_W-bit cycle counter, entries carry stamps
//     not defined : no counter, entries hold a0 only, out_cycle is 0
//
//   Ports:
//     clk        : system clock, rising edge
//     rst        : asynchronous active-low reset
//     a0_in      : CPU a0 value
//     out_valid  : head entry available
//     out_ready  : consumer takes the head this cycle
//     out_data   : head a0 value (0 when empty)
//     out_cycle  : head cycle stamp (0 when empty)
//     count      : entries currently held
//     overflow   : sticky, a change was dropped while full
//
//   Stream handshake: a transfer happens on a rising edge where out_valid and
//   out_ready are both 1. While out_valid=1 and out_ready=0 the head and
//   out_valid hold steady; out_valid never depends on out_ready.
// ----------------------------------------------------------------------------
module a0_trace_fifo
    import a0trace_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int CYC_W      = CYC_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a0_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CYC_W-1:0]      out_cycle,
    output logic [ptr_w(DEPTH):0] count,
    output logic                  overflow
);

`ifdef A0_TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = CYC_W + DATA_WIDTH;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    logic [DATA_WIDTH-1:0] a0_prev;
    logic                  change;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    head;

    // a0_prev resets to 0, so the first nonzero a0 after reset is a change.
    assign change = (a0_in != a0_prev);
    assign pop    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a0_prev  <= '0;
            overflow <= 1'b0;
        end else begin
            a0_prev <= a0_in;
            if (change & full & ~pop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef A0_TRACE_TIMESTAMP_EN
    logic [CYC_W-1:0] cyc;

    // Free-running; wraps silently. The stamp is the value during the cycle
    // in which the change was seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cyc <= '0;
        else      cyc <= cyc + CYC_W'(1);
    end

    assign wr_entry  = {cyc, a0_in};
    assign out_cycle = head[ENTRY_W-1:DATA_WIDTH];
`else
    assign wr_entry  = a0_in;
    assign out_cycle = '0;
`endif

    assign out_data  = head[DATA_WIDTH-1:0];
    assign out_valid = ~empty;

    // The FIFO accepts the push when it has room or when the head leaves in
    // the same cycle; otherwise the change is lost and overflow is set above.
    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (change),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_a0_trace_fifo.sv
// ----------------------------------------------------------------------------
// tb_a0_trace_fifo
//   Directed bench for a0_trace_fifo (DATA_WIDTH=32, DEPTH=8, CYC_W=4 so the
//   stamp wrap is reachable). Inputs change on the falling edge, outputs are
//   sampled on the falling edge after each rising edge.
// ----------------------------------------------------------------------------
module tb_a0_trace_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int EW    = CW + DW;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] a0_in = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_cycle;
    logic [3:0]    count;
    logic          overflow;

    always #5 clk = ~clk;

    a0_trace_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CYC_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a0_in     (a0_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cycle (out_cycle),
        .count     (count),
        .overflow  (overflow)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] m_prev;
    logic [CW-1:0] m_cyc;
    logic          m_ovf;
    int            n_checks = 0;
    int            n_fail   = 0;

    function automatic logic [CW-1:0] stamp_of(input logic [CW-1:0] s);
`ifdef A0_TRACE_TIMESTAMP_EN
        return s;
`else
        return '0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [EW-1:0] h;
        h = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk({tag, ".valid"},    64'(out_valid), 64'(exp_q.size() > 0));
        chk({tag, ".count"},    64'(count),     64'(exp_q.size()));
        chk({tag, ".overflow"}, 64'(overflow),  64'(m_ovf));
        chk({tag, ".data"},     64'(out_data),  64'(h[DW-1:0]));
        chk({tag, ".cycle"},    64'(out_cycle), 64'(stamp_of(h[EW-1:DW])));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_prev = '0;
        m_cyc  = '0;
        m_ovf  = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Apply inputs for one rising edge, update the reference, then sample.
    task automatic tick(input logic [DW-1:0] a0, input logic rdy, input string tag);
        logic          m_change;
        logic          m_full;
        logic          m_pop;
        logic [EW-1:0] tmp;
        a0_in     = a0;
        out_ready = rdy;
        m_change = (a0 != m_prev);
        m_full   = (exp_q.size() == DEPTH);
        m_pop    = (exp_q.size() > 0) && rdy;
        if (m_pop) tmp = exp_q.pop_front();
        if (m_change && (!m_full || m_pop)) exp_q.push_back({m_cyc, a0});
        else if (m_change) m_ovf = 1'b1;
        m_prev = a0;
        m_cyc  = m_cyc + CW'(1);
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic reset_dut(input logic [DW-1:0] a0, input string tag);
        @(negedge clk);
        rst       = 1'b0;
        a0_in     = a0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk({tag, ".rst_valid"},    64'(out_valid), 64'd0);
        chk({tag, ".rst_count"},    64'(count),     64'd0);
        chk({tag, ".rst_data"},     64'(out_data),  64'd0);
        chk({tag, ".rst_cycle"},    64'(out_cycle), 64'd0);
        chk({tag, ".rst_overflow"}, 64'(overflow),  64'd0);
        rst = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [DW-1:0] a0;
        logic          rdy;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic [CW-1:0] exp_cyc;
        logic [3:0]    exp_count;
    } vec_t;

    vec_t vecs[8];
    logic [DW-1:0] drain_exp[8];

    initial begin
        logic [CW-1:0] prev_stamp;

        // Reset held with a0=5, release, first entry {0, 5} next cycle.
        vecs[0] = '{32'd5, 1'b0, 1'b1, 32'd5, 4'd0, 4'd1};
        vecs[1] = '{32'd5, 1'b1, 1'b0, 32'd0, 4'd0, 4'd0};
        vecs[2] = '{32'd7, 1'b0, 1'b1, 32'd7, 4'd2, 4'd1};
        vecs[3] = '{32'd7, 1'b1, 1'b0, 32'd0, 4'd0, 4'd0};
        vecs[4] = '{32'd9, 1'b1, 1'b1, 32'd9, 4'd4, 4'd1};  // no bypass while empty
        vecs[5] = '{32'd3, 1'b1, 1'b1, 32'd3, 4'd5, 4'd1};  // pop and push together
        vecs[6] = '{32'd3, 1'b0, 1'b1, 32'd3, 4'd5, 4'd1};  // head holds while stalled
        vecs[7] = '{32'd3, 1'b1, 1'b0, 32'd0, 4'd0, 4'd0};

        reset_dut(32'd5, "t1");
        for (int i = 0; i < 8; i++) begin
            tick(vecs[i].a0, vecs[i].rdy, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.valid_h", i), 64'(out_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d.data_h", i),  64'(out_data),  64'(vecs[i].exp_data));
            chk($sformatf("vec%0d.cycle_h", i), 64'(out_cycle), 64'(stamp_of(vecs[i].exp_cyc)));
            chk($sformatf("vec%0d.count_h", i), 64'(count),     64'(vecs[i].exp_count));
        end

        // Constant a0: nothing further is queued.
        for (int i = 0; i < 20; i++) tick(32'd3, 1'b1, "hold");
        chk("hold.count_h", 64'(count), 64'd0);

        // Fill to full with the consumer stalled.
        for (int i = 0; i < 8; i++) tick(32'd200 + DW'(i), 1'b0, "fill");
        chk("fill.count_h",    64'(count),    64'd8);
        chk("fill.overflow_h", 64'(overflow), 64'd0);

        // Full, pop and change in the same cycle: no loss.
        tick(32'd300, 1'b1, "fullpop");
        chk("fullpop.count_h",    64'(count),    64'd8);
        chk("fullpop.overflow_h", 64'(overflow), 64'd0);
        chk("fullpop.head_h",     64'(out_data), 64'd201);

        // Two more changes while stalled and full: dropped, overflow set.
        tick(32'd301, 1'b0, "drop");
        tick(32'd302, 1'b0, "drop");
        chk("drop.count_h",    64'(count),    64'd8);
        chk("drop.overflow_h", 64'(overflow), 64'd1);

        // Drain in order with consecutive stamps.
        for (int i = 0; i < 7; i++) drain_exp[i] = 32'd201 + DW'(i);
        drain_exp[7] = 32'd300;
        prev_stamp = '0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d.data_h", k), 64'(out_data), 64'(drain_exp[k]));
            if (k > 0)
                chk($sformatf("drain%0d.stamp_h", k), 64'(out_cycle),
                    64'(stamp_of(prev_stamp + CW'(1))));
            prev_stamp = out_cycle;
            tick(32'd302, 1'b1, "drain");
        end
        chk("drain.valid_h",    64'(out_valid), 64'd0);
        chk("drain.overflow_h", 64'(overflow),  64'd1);

        // Stamp wrap: changes in cycles 14 and 17 with a 4-bit counter.
        reset_dut(32'd0, "t5");
        for (int i = 0; i < 14; i++) tick(32'd0, 1'b0, "wrap_idle");
        tick(32'd11, 1'b0, "wrap14");
        tick(32'd11, 1'b0, "wrap15");
        tick(32'd11, 1'b0, "wrap16");
        tick(32'd12, 1'b0, "wrap17");
        chk("wrap.first_data_h",  64'(out_data),  64'd11);
        chk("wrap.first_stamp_h", 64'(out_cycle), 64'(stamp_of(4'd14)));
        tick(32'd12, 1'b1, "wrap_pop");
        chk("wrap.second_data_h",  64'(out_data),  64'd12);
        chk("wrap.second_stamp_h", 64'(out_cycle), 64'(stamp_of(4'd1)));

        // Asynchronous reset with three entries queued.
        reset_dut(32'd0, "t6");
        tick(32'd1, 1'b0, "q3");
        tick(32'd2, 1'b0, "q3");
        tick(32'd3, 1'b0, "q3");
        chk("q3.count_h", 64'(count), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("async.valid", 64'(out_valid), 64'd0);
        chk("async.count", 64'(count),     64'd0);
        chk("async.data",  64'(out_data),  64'd0);
        model_reset();
        @(negedge clk);
        a0_in = '0;
        rst   = 1'b1;
        tick(32'd0, 1'b1, "post_rst");
        tick(32'd44, 1'b0, "post_rst");
        chk("post_rst.data_h",  64'(out_data),  64'd44);
        chk("post_rst.stamp_h", 64'(out_cycle), 64'(stamp_of(4'd1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
